// File: rtl/periph_bus_arbiter.sv
// Two-master valid/ready arbiter for the peripheral register bus.
// Optional ISSUE-phase timeout abort is enabled by defining ARB_TIMEOUT_EN.
module periph_bus_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned ROUND_ROBIN    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_valid,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,

    input  logic              m1_valid,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,

    output logic              s_valid,
    output logic [ADDR_W-1:0] s_addr,
    output logic [31:0]       s_wdata,
    output logic [3:0]        s_wstrb,
    input  logic              s_ready,
    input  logic [31:0]       s_rdata,

    output logic [1:0]        owner,
    input  logic              err_clr,
    output logic              timeout_err
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e            state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic              last_m1_q, last_m1_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [31:0]       s_wdata_q, s_wdata_d;
    logic [3:0]        s_wstrb_q, s_wstrb_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              pick_m1;

    // On a tie, round robin hands the bus to whichever master did not own it last.
    assign pick_m1 = m1_valid && (!m0_valid || ((ROUND_ROBIN != 0) && !last_m1_q));

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned  CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            set_err;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_m1_d = last_m1_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_wstrb_d = s_wstrb_q;
        rdata_d   = rdata_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        set_err   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (m0_valid || m1_valid) begin
                    state_d   = StIssue;
                    owner_d   = pick_m1 ? 2'b10 : 2'b01;
                    last_m1_d = pick_m1;
                    s_addr_d  = pick_m1 ? m1_addr  : m0_addr;
                    s_wdata_d = pick_m1 ? m1_wdata : m0_wdata;
                    s_wstrb_d = pick_m1 ? m1_wstrb : m0_wstrb;
`ifdef ARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            StIssue: begin
                if (s_ready) begin
                    rdata_d = s_rdata;
                    state_d = StResp;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CntLast) begin
                    rdata_d = ERR_RDATA;
                    state_d = StResp;
                    set_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            StResp: begin
                state_d = StIdle;
                owner_d = 2'b00;
            end
            default: begin
                state_d = StIdle;
                owner_d = 2'b00;
            end
        endcase
`ifdef ARB_TIMEOUT_EN
        // A fresh timeout outranks a simultaneous clear.
        err_d = set_err ? 1'b1 : (err_clr ? 1'b0 : err_q);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            owner_q   <= 2'b00;
            last_m1_q <= 1'b1;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wstrb_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_m1_q <= last_m1_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_wstrb_q <= s_wstrb_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    logic [31:0] unused_cfg;
    assign unused_cfg  = ERR_RDATA ^ 32'(TIMEOUT_CYCLES) ^ {31'd0, err_clr};
    assign timeout_err = 1'b0;
`endif

    // All outputs decode flops only; no master input reaches them combinationally.
    assign s_valid  = (state_q == StIssue);
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_wstrb  = s_wstrb_q;
    assign owner    = owner_q;
    assign m0_ready = (state_q == StResp) && owner_q[0];
    assign m1_ready = (state_q == StResp) && owner_q[1];
    assign m0_rdata = m0_ready ? rdata_q : 32'd0;
    assign m1_rdata = m1_ready ? rdata_q : 32'd0;

endmodule
